// File: rtl/mem_access_initiator_pkg.sv
// -----------------------------------------------------------------------------
// mem_if_pkg
// Shared types for the start/write/addr/data memory strobe interface.
//   mem_state_e : initiator FSM states (IDLE, SETUP, PULSE, HOLD)
//   mem_req_t   : one request record {write, addr, wdata}, shared by the
//                 sequencer and the bench
//   max3        : elaboration helper used to size the phase counter
// -----------------------------------------------------------------------------
package mem_if_pkg;

   localparam int ADDR_W_DEF = 8;
   localparam int DATA_W_DEF = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SETUP = 2'd1,
      PULSE = 2'd2,
      HOLD  = 2'd3
   } mem_state_e;

   typedef struct packed {
      logic                  write;
      logic [ADDR_W_DEF-1:0] addr;
      logic [DATA_W_DEF-1:0] wdata;
   } mem_req_t;

   // Largest of three phase lengths; sizes the shared down-counter.
   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = a;
      if (b > m) begin
         m = b;
      end else begin
         m = m;
      end
      if (c > m) begin
         m = c;
      end else begin
         m = m;
      end
      return m;
   endfunction

endpackage

// File: rtl/mem_access_initiator_if.sv
// -----------------------------------------------------------------------------
// mem_access_initiator_if
// Request/response handshake plus memory strobe bus of the initiator.
//   master : initiator view (drives req_ready, rsp_*, start/write/addr/data,
//            busy; receives req_* and mem_rdata)
//   slave  : requester/memory view (the mirror image)
// -----------------------------------------------------------------------------
interface mem_access_initiator_if
   import mem_if_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF
) ();

   logic              req_valid;
   logic              req_ready;
   logic              req_write;
   logic [ADDR_W-1:0] req_addr;
   logic [DATA_W-1:0] req_wdata;
   logic              rsp_valid;
   logic              rsp_write;
   logic [DATA_W-1:0] rsp_rdata;
   logic [DATA_W-1:0] mem_rdata;
   logic              start;
   logic              write;
   logic [ADDR_W-1:0] addr;
   logic [DATA_W-1:0] data;
   logic              busy;

   modport master (
      input  req_valid, req_write, req_addr, req_wdata, mem_rdata,
      output req_ready, rsp_valid, rsp_write, rsp_rdata,
      output start, write, addr, data, busy
   );

   modport slave (
      output req_valid, req_write, req_addr, req_wdata, mem_rdata,
      input  req_ready, rsp_valid, rsp_write, rsp_rdata,
      input  start, write, addr, data, busy
   );

endinterface

// File: rtl/mem_access_initiator_timer.sv
// -----------------------------------------------------------------------------
// mem_phase_timer
// Loadable down-counter shared by the SETUP, PULSE and HOLD phases.
//   clk, rst_n : clock, asynchronous active-low reset
//   load       : load load_val this cycle (has priority over counting)
//   load_val   : phase length minus one
//   done       : counter is at zero (current phase is in its last cycle)
// -----------------------------------------------------------------------------
module mem_phase_timer #(
   parameter int CNT_W = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   output logic             done
);

   logic [CNT_W-1:0] cnt_r;

   // Count down to zero and park there until the next load.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_r <= {CNT_W{1'b0}};
      end else if (load) begin
         cnt_r <= load_val;
      end else if (cnt_r != {CNT_W{1'b0}}) begin
         cnt_r <= cnt_r - CNT_W'(1'b1);
      end else begin
         cnt_r <= cnt_r;
      end
   end

   assign done = (cnt_r == {CNT_W{1'b0}});

endmodule

// File: rtl/mem_access_initiator.sv
// -----------------------------------------------------------------------------
// mem_access_initiator
// Takes one request at a time and plays it onto the memory strobe bus as
// SETUP (addr/data/write stable, start low), PULSE (start high) and HOLD,
// then returns a one-cycle response carrying read data for reads.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : mem_access_initiator_if.master
//                req_valid/req_ready/req_write/req_addr/req_wdata : request
//                rsp_valid/rsp_write/rsp_rdata                    : response
//                mem_rdata                                         : mem[addr]
//                start/write/addr/data                             : memory bus
//                busy                                              : not IDLE
// -----------------------------------------------------------------------------
module mem_access_initiator
   import mem_if_pkg::*;
#(
   parameter int ADDR_W    = ADDR_W_DEF,
   parameter int DATA_W    = DATA_W_DEF,
   parameter int SETUP_CYC = 1,
   parameter int PULSE_CYC = 2,
   parameter int HOLD_CYC  = 1
) (
   input  logic                   clk,
   input  logic                   rst_n,
   mem_access_initiator_if.master bus
);

   localparam int CNT_W = $clog2(max3(SETUP_CYC, PULSE_CYC, HOLD_CYC)) + 1;

   if (SETUP_CYC < 1) begin : g_bad_setup
      $fatal(1, "mem_access_initiator: SETUP_CYC must be >= 1");
   end
   if (PULSE_CYC < 1) begin : g_bad_pulse
      $fatal(1, "mem_access_initiator: PULSE_CYC must be >= 1");
   end
   if (HOLD_CYC < 1) begin : g_bad_hold
      $fatal(1, "mem_access_initiator: HOLD_CYC must be >= 1");
   end

   mem_state_e        state_r;
   logic              start_r;
   logic              write_r;
   logic [ADDR_W-1:0] addr_r;
   logic [DATA_W-1:0] data_r;
   logic              rsp_valid_r;
   logic              rsp_write_r;
   logic [DATA_W-1:0] rsp_rdata_r;
   logic              busy_r;

   logic              req_ready_s;
   logic              accept_s;
   logic              load_s;
   logic [CNT_W-1:0]  load_val_s;
   logic              phase_done_s;

   assign req_ready_s = (state_r == IDLE);
   assign accept_s    = bus.req_valid & req_ready_s;

   mem_phase_timer #(
      .CNT_W    (CNT_W)
   ) u_timer (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (load_s),
      .load_val (load_val_s),
      .done     (phase_done_s)
   );

   // Reload the shared timer with the length of the phase being entered.
   always_comb begin
      load_s     = 1'b0;
      load_val_s = {CNT_W{1'b0}};
      case (state_r)
         IDLE: begin
            if (accept_s) begin
               load_s     = 1'b1;
               load_val_s = CNT_W'(SETUP_CYC - 1);
            end else begin
               load_s     = 1'b0;
            end
         end
         SETUP: begin
            if (phase_done_s) begin
               load_s     = 1'b1;
               load_val_s = CNT_W'(PULSE_CYC - 1);
            end else begin
               load_s     = 1'b0;
            end
         end
         PULSE: begin
            if (phase_done_s) begin
               load_s     = 1'b1;
               load_val_s = CNT_W'(HOLD_CYC - 1);
            end else begin
               load_s     = 1'b0;
            end
         end
         HOLD: begin
            load_s = 1'b0;
         end
         default: begin
            load_s = 1'b0;
         end
      endcase
   end

   // Phase sequencer; every bus and response output is a flop set here.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r     <= IDLE;
         start_r     <= 1'b0;
         write_r     <= 1'b0;
         addr_r      <= {ADDR_W{1'b0}};
         data_r      <= {DATA_W{1'b0}};
         rsp_valid_r <= 1'b0;
         rsp_write_r <= 1'b0;
         rsp_rdata_r <= {DATA_W{1'b0}};
         busy_r      <= 1'b0;
      end else begin
         rsp_valid_r <= 1'b0;
         case (state_r)
            IDLE: begin
               start_r <= 1'b0;
               if (accept_s) begin
                  // Bus fields change here, at least one cycle before start rises.
                  addr_r  <= bus.req_addr;
                  write_r <= bus.req_write;
                  data_r  <= bus.req_write ? bus.req_wdata : {DATA_W{1'b0}};
                  busy_r  <= 1'b1;
                  state_r <= SETUP;
               end else begin
                  write_r <= 1'b0;
                  busy_r  <= 1'b0;
               end
            end
            SETUP: begin
               if (phase_done_s) begin
                  start_r <= 1'b1;
                  state_r <= PULSE;
               end else begin
                  start_r <= 1'b0;
               end
            end
            PULSE: begin
               if (phase_done_s) begin
                  start_r <= 1'b0;
                  state_r <= HOLD;
               end else begin
                  start_r <= 1'b1;
               end
            end
            HOLD: begin
               start_r <= 1'b0;
               if (phase_done_s) begin
                  rsp_valid_r <= 1'b1;
                  rsp_write_r <= write_r;
                  rsp_rdata_r <= write_r ? {DATA_W{1'b0}} : bus.mem_rdata;
                  write_r     <= 1'b0;
                  busy_r      <= 1'b0;
                  state_r     <= IDLE;
               end else begin
                  busy_r      <= 1'b1;
               end
            end
            default: begin
               start_r <= 1'b0;
               write_r <= 1'b0;
               busy_r  <= 1'b0;
               state_r <= IDLE;
            end
         endcase
      end
   end

   assign bus.req_ready = req_ready_s;
   assign bus.rsp_valid = rsp_valid_r;
   assign bus.rsp_write = rsp_write_r;
   assign bus.rsp_rdata = rsp_rdata_r;
   assign bus.start     = start_r;
   assign bus.write     = write_r;
   assign bus.addr      = addr_r;
   assign bus.data      = data_r;
   assign bus.busy      = busy_r;

endmodule
